// File: rtl/wram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : wram_arbiter                                                     |
// | Purpose  : Single-port word RAM arbiter for main CPU, sub CPU and the       |
// |            rotation/scaling ASIC. Tracks 2M-mode ownership (DMNA/RET swap)  |
// |            and runs one RAM access at a time: IDLE -> ACCESS -> DONE.       |
// | Params   : MEM_LAT    - cycles each access holds the RAM strobes (>=1)     |
// |            STARVE_MAX - CPU grants tolerated before the ASIC is forced in  |
// | Macro    : WRAM_ARB_STARVE_EN - enables the ASIC anti-starvation counter.  |
// |            Undefined: fixed priority main > sub > ASIC.                    |
// | Ports    : clk, rst (sync, active-high)                                   |
// |            wram_mode, main_dmna, sub_ret -> wram_for_sub, swap_pend        |
// |            {m,s,a}_req/addr/we/din -> {m,s,a}_ack, rd_data, asic_stall     |
// |            mem_addr/mem_din/mem_oe/mem_we -> RAM, mem_dout <- RAM          |
// | Revision : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module wram_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wram_mode,
  input  logic        main_dmna,
  input  logic        sub_ret,
  output logic        wram_for_sub,
  output logic        swap_pend,
  input  logic        m_req,
  input  logic        s_req,
  input  logic        a_req,
  input  logic [16:0] m_addr,
  input  logic [16:0] s_addr,
  input  logic [16:0] a_addr,
  input  logic [1:0]  m_we,
  input  logic [1:0]  s_we,
  input  logic [1:0]  a_we,
  input  logic [15:0] m_din,
  input  logic [15:0] s_din,
  input  logic [15:0] a_din,
  output logic        m_ack,
  output logic        s_ack,
  output logic        a_ack,
  output logic [15:0] rd_data,
  output logic        asic_stall,
  output logic [16:0] mem_addr,
  output logic [15:0] mem_din,
  input  logic [15:0] mem_dout,
  output logic        mem_oe,
  output logic [1:0]  mem_we
);

`ifdef WRAM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] SEL_M = 2'd0;
  localparam logic [1:0] SEL_S = 2'd1;
  localparam logic [1:0] SEL_A = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      sel, sel_nx;
  logic [LW-1:0]   lat_cnt;
  logic [16:0]     addr_q;
  logic [15:0]     din_q;
  logic [1:0]      we_q;
  logic [SW-1:0]   starve_cnt;

  logic            elig_m, elig_s, elig_a;
  logic            grant, apply_swap, last_beat, starve_force;

  // Eligibility follows the mode/owner registers as seen in the arbitration
  // cycle, so a wram_mode change lands at the next IDLE decision.
  always_comb begin
    elig_m       = wram_mode | ~wram_for_sub;
    elig_s       = wram_mode |  wram_for_sub;
    elig_a       = ~wram_mode & wram_for_sub;
    starve_force = STARVE_ON && elig_a && a_req && (starve_cnt >= SW'(STARVE_MAX));
    last_beat    = (lat_cnt == LW'(MEM_LAT - 1));
  end

  // Next-state and grant decision.
  always_comb begin
    state_nx   = state;
    sel_nx     = sel;
    grant      = 1'b0;
    apply_swap = 1'b0;
    case (state)
      IDLE: begin
        // A pending ownership swap consumes the IDLE cycle; no grant alongside it.
        if (swap_pend) begin
          apply_swap = 1'b1;
        end else if (starve_force) begin
          grant  = 1'b1;
          sel_nx = SEL_A;
        end else if (m_req && elig_m) begin
          grant  = 1'b1;
          sel_nx = SEL_M;
        end else if (s_req && elig_s) begin
          grant  = 1'b1;
          sel_nx = SEL_S;
        end else if (a_req && elig_a) begin
          grant  = 1'b1;
          sel_nx = SEL_A;
        end
        if (grant) state_nx = ACCESS;
      end
      ACCESS:  if (last_beat) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sel          <= SEL_M;
      lat_cnt      <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      we_q         <= '0;
      rd_data      <= '0;
      wram_for_sub <= 1'b0;
      swap_pend    <= 1'b0;
      starve_cnt   <= '0;
    end else begin
      state <= state_nx;

      if (grant) begin
        sel     <= sel_nx;
        lat_cnt <= '0;
        case (sel_nx)
          SEL_M:   begin addr_q <= m_addr; din_q <= m_din; we_q <= m_we; end
          SEL_S:   begin addr_q <= s_addr; din_q <= s_din; we_q <= s_we; end
          default: begin addr_q <= a_addr; din_q <= a_din; we_q <= a_we; end
        endcase
      end else if (state == ACCESS && !last_beat) begin
        lat_cnt <= lat_cnt + LW'(1);
      end

      if (state == ACCESS && last_beat) rd_data <= mem_dout;

      // Only the pulse matching the current owner can start a swap; the target
      // is always the other owner, so a single pending flag suffices.
      if (apply_swap) begin
        wram_for_sub <= ~wram_for_sub;
        swap_pend    <= 1'b0;
      end else if (!swap_pend &&
                   ((!wram_for_sub && main_dmna) || (wram_for_sub && sub_ret))) begin
        swap_pend <= 1'b1;
      end

      // Counts CPU grants taken while the ASIC was eligible and waiting.
      if (!STARVE_ON || !a_req) begin
        starve_cnt <= '0;
      end else if (grant) begin
        if (sel_nx == SEL_A)
          starve_cnt <= '0;
        else if (elig_a && starve_cnt != SW'(STARVE_MAX))
          starve_cnt <= starve_cnt + SW'(1);
      end
    end
  end

  always_comb begin
    mem_addr   = addr_q;
    mem_din    = din_q;
    mem_we     = (state == ACCESS) ? we_q : 2'b00;
    mem_oe     = (state == ACCESS) && (we_q == 2'b00);
    m_ack      = (state == DONE) && (sel == SEL_M);
    s_ack      = (state == DONE) && (sel == SEL_S);
    a_ack      = (state == DONE) && (sel == SEL_A);
    // The ASIC is only "served" while its own access holds the RAM.
    asic_stall = a_req && !((state == ACCESS) && (sel == SEL_A));
  end

endmodule
`default_nettype wire

// File: tb/tb_wram_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_wram_arbiter                                                  |
// | Purpose  : Directed self-checking bench for wram_arbiter with a RAM model   |
// |            and an in-order scoreboard of expected acks / read data.        |
// | Revision : 1.0 - initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_wram_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wram_mode, main_dmna, sub_ret;
  logic        wram_for_sub, swap_pend;
  logic        m_req, s_req, a_req;
  logic [16:0] m_addr, s_addr, a_addr;
  logic [1:0]  m_we, s_we, a_we;
  logic [15:0] m_din, s_din, a_din;
  logic        m_ack, s_ack, a_ack;
  logic [15:0] rd_data;
  logic        asic_stall;
  logic [16:0] mem_addr;
  logic [15:0] mem_din, mem_dout;
  logic        mem_oe;
  logic [1:0]  mem_we;

  wram_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .wram_mode(wram_mode), .main_dmna(main_dmna),
    .sub_ret(sub_ret), .wram_for_sub(wram_for_sub), .swap_pend(swap_pend),
    .m_req(m_req), .s_req(s_req), .a_req(a_req),
    .m_addr(m_addr), .s_addr(s_addr), .a_addr(a_addr),
    .m_we(m_we), .s_we(s_we), .a_we(a_we),
    .m_din(m_din), .s_din(s_din), .a_din(a_din),
    .m_ack(m_ack), .s_ack(s_ack), .a_ack(a_ack),
    .rd_data(rd_data), .asic_stall(asic_stall),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_oe(mem_oe), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  // RAM model: 1K words, preloaded with a known pattern.
  logic [15:0] ram [0:1023];
  function automatic logic [15:0] pat(input int a);
    logic [15:0] v;
    v = 16'(a * 259) ^ 16'h5A5A;
    return v;
  endfunction
  assign mem_dout = ram[mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_we[1]) ram[mem_addr[9:0]][15:8] <= mem_din[15:8];
    if (mem_we[0]) ram[mem_addr[9:0]][7:0]  <= mem_din[7:0];
  end

  typedef struct packed {
    logic [1:0]  who;   // 0 main, 1 sub, 2 ASIC
    logic        rd;
    logic [15:0] data;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int total_acks = 0, m_acks = 0, s_acks = 0, a_acks = 0;
  int m_left = 0, s_left = 0, a_left = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] who, input logic rd, input logic [15:0] data);
    exp_t e;
    e.who = who; e.rd = rd; e.data = data;
    q.push_back(e);
  endtask

  task automatic wait_total(input int target, input int budget, input string tag);
    int n = 0;
    while (total_acks < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(total_acks), 32'(target));
  endtask

  // Monitor: pops the scoreboard on every ack and models requesters that drop
  // req the cycle after their last ack.
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_excl", {31'd0, mem_oe && (mem_we != 2'b00)}, 32'd0);
      if (m_ack || s_ack || a_ack) begin
        exp_t e;
        logic [1:0] who;
        who = a_ack ? 2'd2 : (s_ack ? 2'd1 : 2'd0);
        check("ack_onehot", 32'(m_ack) + 32'(s_ack) + 32'(a_ack), 32'd1);
        total_acks++;
        if (q.size() == 0) begin
          check("sb_unexpected_ack", {30'd0, who}, 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          check("sb_who", {30'd0, who}, {30'd0, e.who});
          if (e.rd) check("sb_rdata", {16'd0, rd_data}, {16'd0, e.data});
        end
      end
      if (m_ack) begin m_acks++; m_left--; if (m_left <= 0) m_req = 1'b0; end
      if (s_ack) begin s_acks++; s_left--; if (s_left <= 0) s_req = 1'b0; end
      if (a_ack) begin a_acks++; a_left--; if (a_left <= 0) a_req = 1'b0; end
    end
  end

  initial begin
    int snap, snap_a, lat, we_cnt;
    for (int i = 0; i < 1024; i++) ram[i] = pat(i);
    rst = 1'b1; wram_mode = 1'b0; main_dmna = 1'b0; sub_ret = 1'b0;
    m_req = 1'b0; s_req = 1'b0; a_req = 1'b0;
    m_addr = '0; s_addr = '0; a_addr = '0;
    m_we = '0; s_we = '0; a_we = '0;
    m_din = '0; s_din = '0; a_din = '0;
    repeat (3) tick();

    // Reset state
    check("rst_owner", {31'd0, wram_for_sub}, 32'd0);
    check("rst_swap_pend", {31'd0, swap_pend}, 32'd0);
    check("rst_acks", {29'd0, m_ack, s_ack, a_ack}, 32'd0);
    check("rst_strobes", {29'd0, mem_oe, mem_we}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_stall", {31'd0, asic_stall}, 32'd0);
    rst = 1'b0;
    tick();

    // 1: owner=main, sub and ASIC wait; DMNA hands over, sub then ASIC served
    s_addr = 17'h00100; s_we = 2'b00; s_req = 1'b1; s_left = 1;
    a_addr = 17'h00101; a_we = 2'b00; a_req = 1'b1; a_left = 1;
    push(2'd1, 1'b1, pat(17'h00100));
    push(2'd2, 1'b1, pat(17'h00101));
    repeat (6) tick();
    check("t1_stall_wait", {31'd0, asic_stall}, 32'd1);
    check("t1_no_ack", 32'(total_acks), 32'd0);
    main_dmna = 1'b1;
    tick();
    main_dmna = 1'b0;
    check("t1_swap_pend", {31'd0, swap_pend}, 32'd1);
    tick();
    check("t1_swap_done", {31'd0, swap_pend}, 32'd0);
    check("t1_owner_sub", {31'd0, wram_for_sub}, 32'd1);
    tick();
    check("t1_oe", {31'd0, mem_oe}, 32'd1);
    check("t1_addr", {15'd0, mem_addr}, 32'h00100);
    check("t1_stall_sub", {31'd0, asic_stall}, 32'd1);
    repeat (MEM_LAT) tick();
    check("t1_s_ack", {31'd0, s_ack}, 32'd1);
    check("t1_stall_done", {31'd0, asic_stall}, 32'd1);
    tick();
    tick();
    check("t1_stall_served", {31'd0, asic_stall}, 32'd0);
    wait_total(2, 20, "t1_timeout");
    check("t1_stall_idle", {31'd0, asic_stall}, 32'd0);

    // 2: owner=sub, main write waits until RET; then byte write and readback
    m_addr = 17'h00200; m_we = 2'b11; m_din = 16'hBEEF; m_req = 1'b1; m_left = 1;
    push(2'd0, 1'b0, 16'h0000);
    repeat (6) tick();
    check("t2_no_ack", 32'(total_acks), 32'd2);
    sub_ret = 1'b1;
    tick();
    sub_ret = 1'b0;
    check("t2_swap_pend", {31'd0, swap_pend}, 32'd1);
    tick();
    check("t2_owner_main", {31'd0, wram_for_sub}, 32'd0);
    lat = 0; we_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (mem_we == 2'b11) we_cnt++;
      if (m_ack) begin lat = i; break; end
    end
    // grant cycle + MEM_LAT beats, ack in the next cycle
    check("t2_latency", 32'(lat), 32'(MEM_LAT + 1));
    check("t2_we_cycles", 32'(we_cnt), 32'(MEM_LAT));
    tick();
    m_addr = 17'h00200; m_we = 2'b01; m_din = 16'h1234; m_req = 1'b1; m_left = 1;
    push(2'd0, 1'b0, 16'h0000);
    wait_total(4, 20, "t2_bytewr_timeout");
    m_we = 2'b00; m_req = 1'b1; m_left = 1;
    push(2'd0, 1'b1, 16'hBE34);
    wait_total(5, 20, "t2_read_timeout");

    // 3: 1M mode, all three request together; ASIC never served
    wram_mode = 1'b1;
    snap_a = a_acks;
    m_addr = 17'h00300; m_we = 2'b00; m_req = 1'b1; m_left = 1;
    s_addr = 17'h00301; s_we = 2'b00; s_req = 1'b1; s_left = 1;
    a_addr = 17'h00302; a_we = 2'b00; a_req = 1'b1; a_left = 1;
    push(2'd0, 1'b1, pat(17'h00300));
    push(2'd1, 1'b1, pat(17'h00301));
    wait_total(7, 30, "t3_timeout");
    repeat (6) tick();
    check("t3_stall", {31'd0, asic_stall}, 32'd1);
    check("t3_no_a_ack", 32'(a_acks), 32'(snap_a));
    a_req = 1'b0; wram_mode = 1'b0;
    tick();

    // 4: DMNA and RET together with owner=main -> single swap to sub
    main_dmna = 1'b1; sub_ret = 1'b1;
    tick();
    main_dmna = 1'b0; sub_ret = 1'b0;
    check("t4_swap_pend", {31'd0, swap_pend}, 32'd1);
    tick();
    check("t4_owner_sub", {31'd0, wram_for_sub}, 32'd1);
    repeat (3) tick();
    check("t4_owner_stable", {30'd0, wram_for_sub, swap_pend}, 32'd2);

    // 5: reset in the middle of an access
    s_addr = 17'h00120; s_we = 2'b11; s_din = 16'hDEAD; s_req = 1'b1; s_left = 1;
    tick();
    check("t5_we_active", {30'd0, mem_we}, 32'd3);
    rst = 1'b1; s_req = 1'b0;
    tick();
    check("t5_strobes_off", {29'd0, mem_oe, mem_we}, 32'd0);
    check("t5_no_ack", {31'd0, s_ack}, 32'd0);
    check("t5_owner_main", {31'd0, wram_for_sub}, 32'd0);
    rst = 1'b0;
    snap = total_acks;
    repeat (5) tick();
    check("t5_no_late_ack", 32'(total_acks), 32'(snap));

    // 6: owner=sub, sub keeps requesting, ASIC held
    main_dmna = 1'b1;
    tick();
    main_dmna = 1'b0;
    tick();
    check("t6_owner_sub", {31'd0, wram_for_sub}, 32'd1);
    s_addr = 17'h00100; s_we = 2'b00;
    a_addr = 17'h00101; a_we = 2'b00; a_left = 1;
`ifdef WRAM_ARB_STARVE_EN
    s_left = 5;
    for (int i = 0; i < 4; i++) push(2'd1, 1'b1, pat(17'h00100));
    push(2'd2, 1'b1, pat(17'h00101));
    push(2'd1, 1'b1, pat(17'h00100));
`else
    s_left = 8;
    for (int i = 0; i < 8; i++) push(2'd1, 1'b1, pat(17'h00100));
    push(2'd2, 1'b1, pat(17'h00101));
`endif
    s_req = 1'b1; a_req = 1'b1;
    snap = total_acks;
`ifdef WRAM_ARB_STARVE_EN
    wait_total(snap + 6, 60, "t6_timeout");
`else
    wait_total(snap + 9, 80, "t6_timeout");
`endif
    check("t6_sb_empty", 32'(q.size()), 32'd0);
    tick();
    check("t6_reqs_dropped", {30'd0, s_req, a_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
